// File: rtl/melody_sequencer.sv
// Melody sequencer: walks a 32-entry song RAM and drives the speaker clock
// divider's half-period count (maxcount) for the note being played.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   start, stop    single-cycle playback requests (stop has priority)
//   loop_en        restart at address 0 at end of song instead of stopping
//   wr_en/addr/data  song RAM write port, honoured only while idle
//                  entry format: [7:4] note code, [3:0] beats (0 = 16)
//   maxcount       half-period count to the divider, 0 = silence
//   playing        high while loading or playing an entry
//   note_idx       address of the entry currently loaded or sounding
//   done           one-cycle pulse when a non-looping song ends
module melody_sequencer #(
    parameter int unsigned TICKS_PER_BEAT = 12500000,
    parameter int unsigned GAP_TICKS      = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic [15:0] maxcount,
    output logic        playing,
    output logic [4:0]  note_idx,
    output logic        done
);

    localparam logic [23:0] LastTick  = 24'(TICKS_PER_BEAT - 1);
    localparam logic [23:0] GapStart  = 24'(TICKS_PER_BEAT - GAP_TICKS);
    localparam logic [3:0]  CodeEnd   = 4'hF;

    typedef enum logic [1:0] {StIdle, StLoad, StPlay} state_e;

    state_e      state_q, state_d;
    logic [4:0]  note_idx_q, note_idx_d;
    logic [23:0] tick_q, tick_d;
    logic [4:0]  beat_q, beat_d;
    logic [15:0] maxcount_q, maxcount_d;
    logic        done_q, done_d;

    logic [7:0]  mem [32];
    logic [7:0]  rd_data_q;

    function automatic logic [15:0] note_period(input logic [3:0] code);
        case (code)
            4'd1:    note_period = 16'd47778;
            4'd2:    note_period = 16'd45097;
            4'd3:    note_period = 16'd42566;
            4'd4:    note_period = 16'd40177;
            4'd5:    note_period = 16'd37921;
            4'd6:    note_period = 16'd35793;
            4'd7:    note_period = 16'd33784;
            4'd8:    note_period = 16'd31888;
            4'd9:    note_period = 16'd30098;
            4'd10:   note_period = 16'd28409;
            4'd11:   note_period = 16'd26815;
            4'd12:   note_period = 16'd25310;
            4'd13:   note_period = 16'd23889;
            default: note_period = 16'd0;  // rests and end marker
        endcase
    endfunction

    // Song RAM. The read address is the next note index, so the entry for
    // note_idx is already in rd_data_q during LOAD and stays there through
    // PLAY (the RAM cannot change outside IDLE).
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == StIdle)) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[note_idx_d];
    end

    logic [3:0] code;
    logic [4:0] dur;
    logic       last_tick, last_beat, note_end, in_gap, is_end;

    assign code      = rd_data_q[7:4];
    assign dur       = (rd_data_q[3:0] == 4'd0) ? 5'd16 : {1'b0, rd_data_q[3:0]};
    assign last_tick = (tick_q == LastTick);
    assign last_beat = (beat_q == dur - 5'd1);
    assign note_end  = last_tick && last_beat;
    assign in_gap    = last_beat && (tick_q >= GapStart);
    assign is_end    = (code == CodeEnd);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            note_idx_q <= 5'd0;
            tick_q     <= 24'd0;
            beat_q     <= 5'd0;
            maxcount_q <= 16'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            note_idx_q <= note_idx_d;
            tick_q     <= tick_d;
            beat_q     <= beat_d;
            maxcount_q <= maxcount_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        logic song_over;
        state_d    = state_q;
        note_idx_d = note_idx_q;
        tick_d     = tick_q;
        beat_d     = beat_q;
        done_d     = 1'b0;
        song_over  = 1'b0;

        if (stop) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        note_idx_d = 5'd0;
                        state_d    = StLoad;
                    end
                end
                StLoad: begin
                    state_d = StPlay;
                    tick_d  = 24'd0;
                    beat_d  = 5'd0;
                end
                StPlay: begin
                    if (is_end) begin
                        song_over = 1'b1;
                    end else if (note_end) begin
                        if (note_idx_q == 5'd31) begin
                            song_over = 1'b1;
                        end else begin
                            note_idx_d = note_idx_q + 5'd1;
                            state_d    = StLoad;
                        end
                    end else if (last_tick) begin
                        tick_d = 24'd0;
                        beat_d = beat_q + 5'd1;
                    end else begin
                        tick_d = tick_q + 24'd1;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (song_over) begin
                if (loop_en) begin
                    note_idx_d = 5'd0;
                    state_d    = StLoad;
                end else begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
        end
    end

    // Output logic: maxcount is registered, so the tone for a PLAY cycle
    // reaches the divider one cycle later (first tone two edges after start).
    always_comb begin
        maxcount_d = 16'd0;
        if (!stop && (state_q == StPlay) && !is_end && !in_gap) begin
            maxcount_d = note_period(code);
        end
    end

    assign maxcount = maxcount_q;
    assign playing  = (state_q != StIdle);
    assign note_idx = note_idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
module tb_melody_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start, stop, loop_en, wr_en;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] maxcount;
    logic        playing;
    logic [4:0]  note_idx;
    logic        done;

    int checks = 0;
    int errors = 0;
    int vec_no = 0;

    melody_sequencer #(
        .TICKS_PER_BEAT(4),
        .GAP_TICKS     (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .loop_en (loop_en),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .maxcount(maxcount),
        .playing (playing),
        .note_idx(note_idx),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        start;
        logic        stop;
        logic        loop_en;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [7:0]  wr_data;
        logic [15:0] mc;
        logic        pl;
        logic [4:0]  idx;
        logic        dn;
    } vec_t;

    vec_t vecs[$];

    function automatic void push(input logic s, input logic p, input logic l,
                                 input logic w, input logic [4:0] wa, input logic [7:0] wd,
                                 input logic [15:0] mc, input logic pl,
                                 input logic [4:0] idx, input logic dn);
        vec_t v;
        v.start = s; v.stop = p; v.loop_en = l;
        v.wr_en = w; v.wr_addr = wa; v.wr_data = wd;
        v.mc = mc; v.pl = pl; v.idx = idx; v.dn = dn;
        vecs.push_back(v);
    endfunction

    // Idle write; outputs stay silent with note_idx holding idx.
    function automatic void push_write(input logic [4:0] a, input logic [7:0] d,
                                       input logic [4:0] idx);
        push(0, 0, 0, 1, a, d, 16'd0, 0, idx, 0);
    endfunction

    // Song 0xA2, 0xF0 (A5 for 2 beats, then end), optional write attempt mid-note.
    function automatic void push_single(input logic wr_during);
        push(1, 0, 0, 0, 0, 0, 16'd0, 1, 5'd0, 0);      // LOAD 0
        push(0, 0, 0, 0, 0, 0, 16'd0, 1, 5'd0, 0);      // first PLAY cycle
        for (int k = 0; k < 7; k++) begin
            push(0, 0, 0, wr_during && (k == 2), 5'd1, 8'h31, 16'd28409, 1, 5'd0, 0);
        end
        push(0, 0, 0, 0, 0, 0, 16'd0, 1, 5'd1, 0);      // LOAD 1 (gap shown)
        push(0, 0, 0, 0, 0, 0, 16'd0, 1, 5'd1, 0);      // end-marker PLAY cycle
        push(0, 0, 0, 0, 0, 0, 16'd0, 0, 5'd1, 1);      // done pulse
        push(0, 0, 0, 0, 0, 0, 16'd0, 0, 5'd1, 0);
    endfunction

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            start   = vecs[i].start;
            stop    = vecs[i].stop;
            loop_en = vecs[i].loop_en;
            wr_en   = vecs[i].wr_en;
            wr_addr = vecs[i].wr_addr;
            wr_data = vecs[i].wr_data;
            @(posedge clk);
            #1;
            checks++;
            if (maxcount !== vecs[i].mc || playing !== vecs[i].pl ||
                note_idx !== vecs[i].idx || done !== vecs[i].dn) begin
                errors++;
                $display("FAIL vec%0d: got mc=%0d play=%0b idx=%0d done=%0b, want mc=%0d play=%0b idx=%0d done=%0b",
                         vec_no, maxcount, playing, note_idx, done,
                         vecs[i].mc, vecs[i].pl, vecs[i].idx, vecs[i].dn);
            end
            vec_no++;
        end
        start = 0; stop = 0; wr_en = 0; loop_en = 0;
        vecs.delete();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    initial begin
        int  seen;
        int  tone1;
        logic hit;
        start = 0; stop = 0; loop_en = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        rst_n = 0;
        #3;
        check("reset_maxcount", 32'(maxcount), 0);
        check("reset_playing", 32'(playing), 0);
        check("reset_note_idx", 32'(note_idx), 0);
        check("reset_done", 32'(done), 0);
        #9 rst_n = 1;
        @(posedge clk);
        #1;

        // start+stop together stays idle; then single note song
        push(1, 1, 0, 0, 0, 0, 16'd0, 0, 5'd0, 0);
        push_write(5'd0, 8'hA2, 5'd0);
        push_write(5'd1, 8'hF0, 5'd0);
        push(0, 0, 0, 0, 0, 0, 16'd0, 0, 5'd0, 0);
        push_single(1'b0);
        run_vecs();

        // rest of 1 beat, then C5 with zero duration field (16 beats)
        push_write(5'd0, 8'h01, 5'd1);
        push_write(5'd1, 8'h10, 5'd1);
        push_write(5'd2, 8'hF0, 5'd1);
        push(1, 0, 0, 0, 0, 0, 16'd0, 1, 5'd0, 0);
        for (int k = 0; k < 4; k++) push(0, 0, 0, 0, 0, 0, 16'd0, 1, 5'd0, 0);
        push(0, 0, 0, 0, 0, 0, 16'd0, 1, 5'd1, 0);
        push(0, 0, 0, 0, 0, 0, 16'd0, 1, 5'd1, 0);
        for (int k = 0; k < 63; k++) push(0, 0, 0, 0, 0, 0, 16'd47778, 1, 5'd1, 0);
        push(0, 0, 0, 0, 0, 0, 16'd0, 1, 5'd2, 0);
        push(0, 0, 0, 0, 0, 0, 16'd0, 1, 5'd2, 0);
        push(0, 0, 0, 0, 0, 0, 16'd0, 0, 5'd2, 1);
        push(0, 0, 0, 0, 0, 0, 16'd0, 0, 5'd2, 0);
        run_vecs();

        // looping, start mid-song ignored, stop aborts
        push_write(5'd0, 8'h51, 5'd2);
        push_write(5'd1, 8'hF0, 5'd2);
        push(1, 0, 1, 0, 0, 0, 16'd0, 1, 5'd0, 0);
        push(0, 0, 1, 0, 0, 0, 16'd0, 1, 5'd0, 0);
        for (int k = 0; k < 3; k++) push(0, 0, 1, 0, 0, 0, 16'd37921, 1, 5'd0, 0);
        push(0, 0, 1, 0, 0, 0, 16'd0, 1, 5'd1, 0);
        push(1, 0, 1, 0, 0, 0, 16'd0, 1, 5'd1, 0);     // start while playing
        push(0, 0, 1, 0, 0, 0, 16'd0, 1, 5'd0, 0);     // loop back to LOAD 0
        push(0, 0, 1, 0, 0, 0, 16'd0, 1, 5'd0, 0);
        for (int k = 0; k < 2; k++) push(0, 0, 1, 0, 0, 0, 16'd37921, 1, 5'd0, 0);
        push(0, 1, 1, 0, 0, 0, 16'd0, 0, 5'd0, 0);     // stop mid-tone
        push(0, 0, 1, 0, 0, 0, 16'd0, 0, 5'd0, 0);
        run_vecs();

        // address wrap: 32 x D5 one beat, no end marker
        for (int a = 0; a < 32; a++) push_write(5'(a), 8'h31, 5'd0);
        push(1, 0, 0, 0, 0, 0, 16'd0, 1, 5'd0, 0);
        for (int n = 0; n < 32; n++) begin
            push(0, 0, 0, 0, 0, 0, 16'd0, 1, 5'(n), 0);
            for (int k = 0; k < 3; k++) push(0, 0, 0, 0, 0, 0, 16'd42566, 1, 5'(n), 0);
            if (n < 31) push(0, 0, 0, 0, 0, 0, 16'd0, 1, 5'(n + 1), 0);
        end
        push(0, 0, 0, 0, 0, 0, 16'd0, 0, 5'd31, 1);
        push(0, 0, 0, 0, 0, 0, 16'd0, 0, 5'd31, 0);
        run_vecs();

        // write during play is ignored: second playback must be identical
        push_write(5'd0, 8'hA2, 5'd31);
        push_write(5'd1, 8'hF0, 5'd31);
        push_single(1'b1);
        push_single(1'b0);
        run_vecs();

        // async reset mid-note
        push_write(5'd0, 8'h51, 5'd1);
        push_write(5'd1, 8'h81, 5'd1);
        push_write(5'd2, 8'hF0, 5'd1);
        run_vecs();
        start = 1;
        @(posedge clk); #1;
        start = 0;
        hit = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(posedge clk); #1;
            if (note_idx == 5'd1 && maxcount == 16'd31888) hit = 1;
        end
        check("reach_note1_tone", 32'(hit), 1);
        #2 rst_n = 0;
        #1;
        check("async_maxcount", 32'(maxcount), 0);
        check("async_playing", 32'(playing), 0);
        check("async_note_idx", 32'(note_idx), 0);
        check("async_done", 32'(done), 0);
        #3 rst_n = 1;
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        check("restart_load_idx", 32'(note_idx), 0);
        check("restart_load_playing", 32'(playing), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("restart_first_tone", 32'(maxcount), 37921);
        seen = 0;
        tone1 = 0;
        for (int c = 0; c < 60 && seen == 0; c++) begin
            @(posedge clk); #1;
            if (maxcount == 16'd31888) tone1++;
            if (done) seen = 1;
        end
        check("restart_done_seen", 32'(seen), 1);
        check("restart_done_idx", 32'(note_idx), 2);
        check("restart_note1_cycles", 32'(tone1), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
